// File: rtl/cic_sched.sv
// cic_sched: round-robin scheduler sharing one CIC core between NCH requesters, with per-channel decimation.
// Optional feature macro CIC_SCHED_STALL_CNT_EN adds stall_cnt_o, a saturating count of EMIT cycles without out_ready_i.
module cic_sched #(
   parameter int NCH      = 4,
   parameter int DW       = 8,
   parameter int DEC_W    = 8,
   parameter int CORE_LAT = 1
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   en_i,
   input  logic [DEC_W-1:0]       dec_ratio_i,
   input  logic [NCH-1:0]         req_valid_i,
   input  logic [NCH*DW-1:0]      req_data_i,
   output logic [NCH-1:0]         req_ready_o,
   output logic                   core_valid_o,
   output logic [DW-1:0]          core_data_o,
   output logic [$clog2(NCH)-1:0] core_ch_o,
   input  logic [DW-1:0]          core_y_i,
   output logic                   out_valid_o,
   output logic [DW-1:0]          out_data_o,
   output logic [$clog2(NCH)-1:0] out_ch_o,
`ifdef CIC_SCHED_STALL_CNT_EN
   output logic [15:0]            stall_cnt_o,
`endif
   input  logic                   out_ready_i
);
   localparam int CW = $clog2(NCH);

   typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT, EMIT} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    last_q, last_d, ch_q, ch_d, out_ch_q, out_ch_d;
   logic [DW-1:0]    smp_q, smp_d, out_data_q, out_data_d;
   logic [3:0]       lat_q, lat_d;
   logic [DEC_W-1:0] dec_q [NCH];
   logic [DEC_W-1:0] dec_d [NCH];
   logic [DW-1:0]    req_arr [NCH];
   logic [CW-1:0]    gnt, idx;
   logic             gnt_vld;
   logic [DEC_W-1:0] r_m1;

   for (genvar k = 0; k < NCH; k++) begin : g_req
      assign req_arr[k] = req_data_i[k*DW +: DW];
   end

   // a ratio of 0 behaves as 1, so the hit threshold is Reff-1
   assign r_m1 = (dec_ratio_i == '0) ? '0 : dec_ratio_i - DEC_W'(1);

   // round-robin search: the valid channel nearest above last_q wins, so scan from farthest to nearest
   always_comb begin
      gnt = '0;
      gnt_vld = 1'b0;
      idx = '0;
      for (int i = NCH; i >= 1; i--) begin
         idx = CW'((int'(last_q) + i) % NCH);
         if (req_valid_i[idx]) begin
            gnt = idx;
            gnt_vld = 1'b1;
         end
      end
   end

   // next-state and datapath updates for one ARB..EMIT transaction
   always_comb begin
      state_d = state_q;
      last_d = last_q;
      ch_d = ch_q;
      smp_d = smp_q;
      out_ch_d = out_ch_q;
      out_data_d = out_data_q;
      lat_d = lat_q;
      dec_d = dec_q;
      req_ready_o = '0;
      case (state_q)
         IDLE: state_d = (en_i && |req_valid_i) ? ARB : IDLE;
         ARB: begin
            state_d = gnt_vld ? ISSUE : IDLE;
            if (gnt_vld) begin
               req_ready_o[gnt] = 1'b1;
               ch_d = gnt;
               last_d = gnt;
               smp_d = req_arr[gnt];
            end
         end
         ISSUE: begin
            lat_d = 4'(CORE_LAT);
            state_d = WAIT;
         end
         WAIT: begin
            lat_d = lat_q - 4'd1;
            if (lat_q == 4'd1) begin
               if (dec_q[ch_q] >= r_m1) begin
                  dec_d[ch_q] = '0;
                  out_data_d = core_y_i;
                  out_ch_d = ch_q;
                  state_d = EMIT;
               end else begin
                  dec_d[ch_q] = dec_q[ch_q] + DEC_W'(1);
                  state_d = IDLE;
               end
            end
         end
         EMIT: state_d = out_ready_i ? IDLE : EMIT;
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers; reset aborts any transaction in flight
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         last_q <= CW'(NCH - 1);
         ch_q <= '0;
         smp_q <= '0;
         out_ch_q <= '0;
         out_data_q <= '0;
         lat_q <= '0;
         dec_q <= '{default: '0};
      end else begin
         state_q <= state_d;
         last_q <= last_d;
         ch_q <= ch_d;
         smp_q <= smp_d;
         out_ch_q <= out_ch_d;
         out_data_q <= out_data_d;
         lat_q <= lat_d;
         dec_q <= dec_d;
      end
   end

   assign core_valid_o = (state_q == ISSUE);
   assign core_data_o  = smp_q;
   assign core_ch_o    = ch_q;
   assign out_valid_o  = (state_q == EMIT);
   assign out_data_o   = out_data_q;
   assign out_ch_o     = out_ch_q;

`ifdef CIC_SCHED_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;
   logic        en_q;

   // count back-pressured EMIT cycles, saturating; a rising en_i restarts the count
   always_comb stall_d = (en_i && !en_q) ? 16'd0 :
                         (state_q == EMIT && !out_ready_i && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;

   // stall counter and en_i edge-detect registers
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         stall_q <= '0;
         en_q <= 1'b0;
      end else begin
         stall_q <= stall_d;
         en_q <= en_i;
      end
   end

   assign stall_cnt_o = stall_q;
`endif
endmodule

// File: tb/tb_cic_sched.sv
// tb_cic_sched: directed self-checking bench for cic_sched with a requester model, echo core and event monitor.
module tb_cic_sched;
   localparam int NCH = 4;
   localparam int DW  = 8;

   logic              clk = 1'b0;
   logic              rstn_i = 1'b1;
   logic              en_i = 1'b1;
   logic [7:0]        dec_ratio_i = 8'd1;
   logic [NCH-1:0]    req_valid_i = '0;
   logic [NCH*DW-1:0] req_data_i = '0;
   logic [NCH-1:0]    req_ready_o;
   logic              core_valid_o;
   logic [DW-1:0]     core_data_o;
   logic [1:0]        core_ch_o;
   logic [DW-1:0]     core_y_i = 8'hEE;
   logic              out_valid_o;
   logic [DW-1:0]     out_data_o;
   logic [1:0]        out_ch_o;
   logic              out_ready_i = 1'b1;
`ifdef CIC_SCHED_STALL_CNT_EN
   logic [15:0]       stall_cnt_o;
`endif

   int checks = 0;
   int passed = 0;

   cic_sched #(.NCH(NCH), .DW(DW), .DEC_W(8), .CORE_LAT(1)) dut (
      .clk_i(clk), .rstn_i(rstn_i), .en_i(en_i), .dec_ratio_i(dec_ratio_i),
      .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
      .core_valid_o(core_valid_o), .core_data_o(core_data_o), .core_ch_o(core_ch_o),
      .core_y_i(core_y_i), .out_valid_o(out_valid_o), .out_data_o(out_data_o),
      .out_ch_o(out_ch_o),
`ifdef CIC_SCHED_STALL_CNT_EN
      .stall_cnt_o(stall_cnt_o),
`endif
      .out_ready_i(out_ready_i)
   );

   always #5 clk = ~clk;

   // echo core: result valid exactly one cycle after issue, junk otherwise
   always @(posedge clk) core_y_i <= core_valid_o ? core_data_o : 8'hEE;

   // requester model: per-channel FIFOs, valid held until the grant is seen
   logic [7:0]     rmem [NCH][32];
   int             rh [NCH];
   int             rt [NCH];
   logic [NCH-1:0] rdy_seen = '0;

   always @(posedge clk) begin
      #1;
      for (int k = 0; k < NCH; k++) begin
         if (rdy_seen[k]) rh[k]++;
         req_valid_i[k] = (rh[k] != rt[k]);
         req_data_i[k*DW +: DW] = rmem[k][rh[k] % 32];
      end
   end

   // monitor: logs grants, issues, output rises and output handshakes per cycle
   int         cyc = 0;
   int         multi = 0;
   int         gr_ch[$];
   int         gr_cyc[$];
   int         iss_cyc[$];
   int         ov_rise[$];
   logic [7:0] od[$];
   int         oc[$];
   logic       ov_prev = 1'b0;

   always begin
      @(negedge clk);
      #2;
      cyc++;
      rdy_seen = req_ready_o;
      if ($countones(req_ready_o) > 1) multi++;
      for (int k = 0; k < NCH; k++)
         if (req_ready_o[k]) begin
            gr_ch.push_back(k);
            gr_cyc.push_back(cyc);
         end
      if (core_valid_o) iss_cyc.push_back(cyc);
      if (out_valid_o && !ov_prev) ov_rise.push_back(cyc);
      if (out_valid_o && out_ready_i) begin
         od.push_back(out_data_o);
         oc.push_back(int'(out_ch_o));
      end
      ov_prev = out_valid_o;
   end

   task automatic push(input int ch, input logic [7:0] d);
      rmem[ch][rt[ch] % 32] = d;
      rt[ch]++;
   endtask

   task automatic clr();
      gr_ch.delete();
      gr_cyc.delete();
      iss_cyc.delete();
      ov_rise.delete();
      od.delete();
      oc.delete();
   endtask

   function automatic bit pending();
      bit p = 1'b0;
      for (int k = 0; k < NCH; k++) if (rh[k] != rt[k]) p = 1'b1;
      return p;
   endfunction

   task automatic drain(input string tag);
      int n = 0;
      while (pending() && n < 500) begin
         @(negedge clk);
         n++;
      end
      repeat (10) @(negedge clk);
      checks++;
      if (n >= 500) $display("FAIL %s_drain: requests still pending after %0d cycles, required 0", tag, n);
      else passed++;
   endtask

   task automatic test_reset();
      int rel;
      int n = 0;
      #1 rstn_i = 1'b0;
      dec_ratio_i = 8'd1;
      for (int k = 0; k < NCH; k++) push(k, 8'(8'hA0 + k));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({req_ready_o, core_valid_o, core_data_o, core_ch_o, out_valid_o, out_data_o, out_ch_o} !== '0)
            $display("FAIL reset_outputs[%0d]: got rdy=%b cv=%b cd=%h cc=%0d ov=%b od=%h oc=%0d, required all 0",
                     i, req_ready_o, core_valid_o, core_data_o, core_ch_o, out_valid_o, out_data_o, out_ch_o);
         else passed++;
      end
      @(posedge clk);
      #1 rstn_i = 1'b1;
      clr();
      rel = cyc;
      while (gr_ch.size() == 0 && n < 20) begin
         @(negedge clk);
         #3;
         n++;
      end
      checks++;
      if (gr_ch.size() == 0 || gr_ch[0] != 0) $display("FAIL reset_first_grant: got %0d grants (first %0d), required channel 0", gr_ch.size(), gr_ch.size() ? gr_ch[0] : -1);
      else passed++;
      checks++;
      if (gr_cyc.size() == 0 || gr_cyc[0] < rel + 2) $display("FAIL reset_first_arb_cycle: got cycle %0d, required >= %0d", gr_cyc.size() ? gr_cyc[0] : -1, rel + 2);
      else passed++;
      drain("reset");
      checks++;
      if (od.size() != 4 || od[0] !== 8'hA0 || od[3] !== 8'hA3 || oc[3] != 3)
         $display("FAIL reset_drain_outputs: got %0d outputs, required 4 (A0..A3 on ch 0..3)", od.size());
      else passed++;
   endtask

   task automatic test_round_robin();
      int         exp_ch[5] = '{0, 1, 2, 3, 0};
      logic [7:0] exp_d[5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
      clr();
      dec_ratio_i = 8'd1;
      push(0, 8'h10); push(1, 8'h20); push(2, 8'h30); push(3, 8'h40); push(0, 8'h50);
      drain("rr");
      checks++;
      if (gr_ch.size() != 5 || od.size() != 5 || iss_cyc.size() != 5 || ov_rise.size() != 5)
         $display("FAIL rr_counts: got grants=%0d outs=%0d issues=%0d rises=%0d, required 5 each", gr_ch.size(), od.size(), iss_cyc.size(), ov_rise.size());
      else begin
         passed++;
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (gr_ch[i] != exp_ch[i] || oc[i] != exp_ch[i] || od[i] !== exp_d[i])
               $display("FAIL rr_item[%0d]: got grant=%0d ch=%0d data=%h, required grant=%0d ch=%0d data=%h", i, gr_ch[i], oc[i], od[i], exp_ch[i], exp_ch[i], exp_d[i]);
            else passed++;
            checks++;
            if (iss_cyc[i] != gr_cyc[i] + 1 || ov_rise[i] != iss_cyc[i] + 2)
               $display("FAIL rr_timing[%0d]: got arb=%0d issue=%0d out=%0d, required issue=arb+1 out=issue+2", i, gr_cyc[i], iss_cyc[i], ov_rise[i]);
            else passed++;
         end
      end
   endtask

   task automatic test_dec3();
      clr();
      dec_ratio_i = 8'd3;
      for (int i = 1; i <= 6; i++) push(2, 8'(8'h60 + i));
      drain("dec3");
      checks++;
      if (ov_rise.size() != 2 || od.size() != 2 || iss_cyc.size() != 6)
         $display("FAIL dec3_count: got pulses=%0d outs=%0d issues=%0d, required 2/2/6", ov_rise.size(), od.size(), iss_cyc.size());
      else begin
         passed++;
         checks++;
         if (od[0] !== 8'h63 || od[1] !== 8'h66 || oc[0] != 2 || oc[1] != 2)
            $display("FAIL dec3_data: got %h/ch%0d %h/ch%0d, required 63/ch2 66/ch2", od[0], oc[0], od[1], oc[1]);
         else passed++;
         checks++;
         if (ov_rise[0] != iss_cyc[2] + 2 || ov_rise[1] != iss_cyc[5] + 2)
            $display("FAIL dec3_when: got rises %0d,%0d, required %0d,%0d", ov_rise[0], ov_rise[1], iss_cyc[2] + 2, iss_cyc[5] + 2);
         else passed++;
      end
   endtask

   task automatic test_dec0();
      clr();
      dec_ratio_i = 8'd0;
      push(1, 8'h51); push(1, 8'h52); push(1, 8'h53);
      drain("dec0");
      checks++;
      if (od.size() != 3 || od[0] !== 8'h51 || od[1] !== 8'h52 || od[2] !== 8'h53 || oc[2] != 1)
         $display("FAIL dec0_every_sample: got %0d outputs, required 3 (51,52,53 on ch1)", od.size());
      else passed++;
   endtask

   task automatic test_ratio_change();
      clr();
      dec_ratio_i = 8'd4;
      push(3, 8'h81); push(3, 8'h82); push(3, 8'h83);
      drain("r4");
      checks++;
      if (od.size() != 0) $display("FAIL r4_no_emit: got %0d outputs, required 0", od.size());
      else passed++;
      clr();
      dec_ratio_i = 8'd2;
      push(3, 8'h84); push(3, 8'h85); push(3, 8'h86);
      drain("r2");
      checks++;
      if (od.size() != 2 || od[0] !== 8'h84 || od[1] !== 8'h86 || oc[0] != 3 || oc[1] != 3)
         $display("FAIL r4to2_emit: got %0d outputs (first %h), required 2 (84,86 on ch3)", od.size(), od.size() ? od[0] : 8'h00);
      else passed++;
   endtask

   task automatic test_stall();
      int n = 0;
      int ng;
      clr();
      dec_ratio_i = 8'd1;
      out_ready_i = 1'b0;
      push(0, 8'h70); push(0, 8'h71); push(1, 8'h72);
      while (!out_valid_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!out_valid_o || out_data_o !== 8'h70 || out_ch_o != 2'd0)
         $display("FAIL stall_first_out: got valid=%b data=%h ch=%0d, required 1/70/0", out_valid_o, out_data_o, out_ch_o);
      else passed++;
      ng = gr_ch.size();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (!out_valid_o || out_data_o !== 8'h70 || out_ch_o != 2'd0 || req_ready_o != '0)
            $display("FAIL stall_hold[%0d]: got valid=%b data=%h ch=%0d rdy=%b, required 1/70/0/0000", i, out_valid_o, out_data_o, out_ch_o, req_ready_o);
         else passed++;
      end
      checks++;
      if (gr_ch.size() != ng) $display("FAIL stall_no_grant: got %0d grants, required %0d", gr_ch.size(), ng);
      else passed++;
`ifdef CIC_SCHED_STALL_CNT_EN
      checks++;
      if (stall_cnt_o !== 16'd10) $display("FAIL stall_cnt: got %0d, required 10", stall_cnt_o);
      else passed++;
`endif
      #1 out_ready_i = 1'b1;
      drain("stall");
      checks++;
      if (od.size() != 3 || od[0] !== 8'h70 || od[1] !== 8'h72 || od[2] !== 8'h71 || oc[0] != 0 || oc[1] != 1 || oc[2] != 0)
         $display("FAIL stall_after: got %0d outputs, required 3 (70/ch0, 72/ch1, 71/ch0)", od.size());
      else passed++;
   endtask

   task automatic test_reset_wait();
      int n = 0;
      clr();
      dec_ratio_i = 8'd2;
      push(1, 8'h91);
      drain("rw_pre");
      push(1, 8'h92);
      while (!core_valid_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!core_valid_o || core_data_o !== 8'h92) $display("FAIL rw_issue: got valid=%b data=%h, required 1/92", core_valid_o, core_data_o);
      else passed++;
      @(posedge clk);
      #1 rstn_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({req_ready_o, core_valid_o, out_valid_o, out_data_o, out_ch_o} !== '0)
            $display("FAIL rw_in_reset[%0d]: got rdy=%b cv=%b ov=%b od=%h oc=%0d, required all 0", i, req_ready_o, core_valid_o, out_valid_o, out_data_o, out_ch_o);
         else passed++;
      end
      @(posedge clk);
      #1 rstn_i = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (od.size() != 0 || ov_rise.size() != 0) $display("FAIL rw_no_capture: got outs=%0d pulses=%0d, required 0/0", od.size(), ov_rise.size());
      else passed++;
      push(1, 8'h93);
      drain("rw_a");
      checks++;
      if (od.size() != 0) $display("FAIL rw_cnt_cleared: got %0d outputs after first post-reset sample, required 0", od.size());
      else passed++;
      push(1, 8'h94);
      drain("rw_b");
      checks++;
      if (od.size() != 1 || od[0] !== 8'h94 || oc[0] != 1) $display("FAIL rw_second_emit: got %0d outputs, required 1 (94 on ch1)", od.size());
      else passed++;
   endtask

   task automatic test_enable();
      int n = 0;
      clr();
      dec_ratio_i = 8'd1;
      en_i = 1'b0;
      push(2, 8'hA5);
      repeat (12) @(negedge clk);
      checks++;
      if (gr_ch.size() != 0) $display("FAIL en_off_grant: got %0d grants, required 0", gr_ch.size());
      else passed++;
      en_i = 1'b1;
      drain("en_on");
      checks++;
      if (od.size() != 1 || od[0] !== 8'hA5 || oc[0] != 2) $display("FAIL en_on_out: got %0d outputs, required 1 (A5 on ch2)", od.size());
      else passed++;
      clr();
      push(0, 8'hB1);
      while (req_ready_o == '0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      #1 en_i = 1'b0;
      push(0, 8'hB2);
      repeat (15) @(negedge clk);
      checks++;
      if (od.size() != 1 || od[0] !== 8'hB1 || gr_ch.size() != 1)
         $display("FAIL en_mid_finish: got outs=%0d grants=%0d, required 1 output (B1) and 1 grant", od.size(), gr_ch.size());
      else passed++;
      en_i = 1'b1;
      drain("en_resume");
      checks++;
      if (od.size() != 2 || od[1] !== 8'hB2) $display("FAIL en_resume: got %0d outputs, required 2 ending with B2", od.size());
      else passed++;
      checks++;
      if (multi != 0) $display("FAIL ready_onehot: got %0d multi-bit ready cycles, required 0", multi);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_dec3();
      test_dec0();
      test_ratio_change();
      test_stall();
      test_reset_wait();
      test_enable();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/cic_sched.md
Name: cic_sched

Overview:
- Time-multiplexed scheduler that shares one 8-bit CIC comb/integrator core between NCH sample requesters.
- Arbitrates requesters round-robin, issues one sample at a time to the core tagged with its channel ID, and waits the core's fixed latency before capturing the result.
- Applies per-channel decimation and presents decimated results on a single valid/ready output.
- Sits between the ADC-side sample sources and the downstream decimated-data consumer.

Parameters:
- NCH, 4, number of requesting channels (2..16).
- DW, 8, sample/result width.
- DEC_W, 8, width of the decimation ratio and the per-channel decimation counters.
- CORE_LAT, 1, cycles from core_valid_o to a valid core_y_i (1..15).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- en_i  in  1  scheduler enable.
- dec_ratio_i  in  DEC_W  decimation ratio R; 0 is treated as 1.
- req_valid_i  in  NCH  per-channel sample valid.
- req_data_i  in  NCH*DW  per-channel sample; channel k occupies [k*DW +: DW].
- req_ready_o  out  NCH  per-channel accept strobe, one-hot.
- core_valid_o  out  1  sample issue strobe to the core.
- core_data_o  out  DW  sample to the core.
- core_ch_o  out  $clog2(NCH)  channel tag to the core.
- core_y_i  in  DW  core result.
- out_valid_o  out  1  decimated result valid.
- out_data_o  out  DW  decimated result.
- out_ch_o  out  $clog2(NCH)  channel of the result.
- out_ready_i  in  1  consumer ready.

Behaviour:
- Reset: clk_i single clock; rstn_i asynchronous, active-low. Every output resets to 0, FSM to IDLE, last-grant pointer to NCH-1, and all decimation counters to 0.
- States: IDLE, ARB, ISSUE, WAIT, EMIT.
- IDLE:
  - en_i=1 and |req_valid_i -> ARB.
  - Otherwise stay.
- ARB, one cycle:
  - Grant the first valid channel searching upward from last_grant+1, wrapping at NCH.
  - Assert req_ready_o[g] for this cycle only; the handshake completes here.
  - Latch req_data_i[g] and g; update last_grant=g.
  - -> ISSUE.
- Requester rule: a requester holds valid and data stable until it receives ready. If its valid drops before grant, it is simply not selected.
- ISSUE, one cycle:
  - core_valid_o=1, with core_data_o/core_ch_o equal to the latched sample and channel.
  - Load the latency counter with CORE_LAT; -> WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When it reaches 0, i.e. CORE_LAT cycles after the ISSUE cycle, capture core_y_i.
  - Let Reff = max(dec_ratio_i,1). If dec_cnt[g] == Reff-1: clear dec_cnt[g], load out_data_o/out_ch_o, -> EMIT.
  - Else: dec_cnt[g]++, -> IDLE.
- EMIT:
  - out_valid_o=1; out_data_o and out_ch_o stay stable until out_ready_i=1.
  - On the handshake cycle, deassert out_valid_o the next cycle and go -> IDLE.
  - out_ready_i asserted in the same cycle out_valid_o rises completes the transfer immediately.
- Minimum sample period is 3+CORE_LAT cycles per accepted sample (ARB, ISSUE, WAIT, then IDLE). The EMIT stall adds to this.
- en_i:
  - Sampled only in IDLE.
  - Deasserting it mid-transaction lets the current ARB..EMIT sequence finish; then the block stays in IDLE.
- dec_ratio_i changes:
  - Take effect at the next compare.
  - If dec_cnt >= Reff-1 at compare, the compare counts as a hit and the counter clears. No counter ever wraps past Reff-1.
- Channel counters are independent. R=1 emits every sample.
- Asynchronous reset mid-operation aborts any transaction. No req_ready_o, core_valid_o or out_valid_o pulse follows the reset release until a fresh ARB or EMIT.
- At most one bit of req_ready_o is ever high. core_valid_o never asserts outside ISSUE.

Optional Feature:
- Macro: CIC_SCHED_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt_o, 16 bits.
  - Counts cycles in EMIT with out_ready_i=0, saturating at 16'hFFFF.
  - Resets to 0 on rstn_i and on the rising edge of en_i.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, with rstn_i low for 3 cycles while all req_valid_i=1 -> all outputs 0; first ARB occurs no earlier than 1 cycle after release; channel 0 is granted first.
- NCH=4, R=1, CORE_LAT=1, all four valid with data 8'h10,8'h20,8'h30,8'h40, core_y_i echoing the sample one cycle later, out_ready_i=1 -> grants in order 0,1,2,3,0; out_ch_o sequence 0,1,2,3; out_data_o 8'h10..8'h40; each core_valid_o precedes its capture by exactly 1 cycle.
- R=3, only channel 2 valid, 6 samples -> exactly 2 out_valid_o pulses, both with out_ch_o=2, after samples 3 and 6.
- dec_ratio_i=0 -> behaves as R=1. Changing R from 4 to 2 when dec_cnt=3 -> emit at the next sample and the counter clears to 0.
- out_ready_i held low 10 cycles in EMIT -> out_data_o/out_ch_o stable, no new req_ready_o pulse. With CIC_SCHED_STALL_CNT_EN, stall_cnt_o=10.
- Reset asserted during WAIT -> no capture and no out_valid_o; dec_cnt cleared, so the next R=2 stream emits on its second sample.
